// File: rtl/access_requester.sv
// -----------------------------------------------------------------------------
// access_requester
//   Initiator side of the request/confirm password-access handshake. Captures a
//   password and data nibble on an accepted start, presents them to the access
//   FSM with request/confirm, then waits for evenEnable/oddEnable. A reply is
//   graded against the parity of the captured data (d[0]). A silent WAIT window
//   is retried after a one-cycle request-low gap.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle command strobe, taken only in IDLE
//   pw_in, data_in        password / data nibble captured at accept
//   busy, done            transaction in flight / one-cycle completion pulse
//   granted, parity_err,  outcome, valid with done and held until the next
//   timeout_err, attempts accepted start (attempts = attempts used - 1)
//   request, confirm,     handshake toward the access FSM
//   passedData, d
//   evenEnable, oddEnable replies from the access FSM
//   locked                only with ACCESS_REQ_LOCKOUT_EN defined
//
// Optional feature (macro ACCESS_REQ_LOCKOUT_EN): three consecutive failed
// transactions (parity or timeout) set locked and block start until reset.
// -----------------------------------------------------------------------------
module access_requester #(
  parameter int ARM_CYC   = 2,
  parameter int HOLD_CYC  = 3,
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 2,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] pw_in,
  input  logic [3:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       granted,
  output logic       parity_err,
  output logic       timeout_err,
  output logic [1:0] attempts,
  output logic       request,
  output logic       confirm,
  output logic [3:0] passedData,
  output logic [3:0] d,
  input  logic       evenEnable,
  input  logic       oddEnable
`ifdef ACCESS_REQ_LOCKOUT_EN
  ,
  output logic       locked
`endif
);

  // state   | meaning
  // IDLE    | waiting for start
  // ARM     | request high, confirm low
  // PRESENT | request and confirm high, replies ignored
  // WAIT    | request and confirm high, replies graded
  // GAP     | one cycle with request low before a retry
  // DONE    | done pulse, outcome latched
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_PRESENT = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] retry_q, retry_d;
  logic [3:0]    pw_q, pw_d;
  logic [3:0]    dat_q, dat_d;
  logic          granted_q, granted_d;
  logic          perr_q, perr_d;
  logic          tmo_q, tmo_d;
  logic [1:0]    att_q, att_d;
  logic          request_q, request_d;
  logic          confirm_q, confirm_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          lock_block;
  logic          en_expected, en_other;

  // The line matching the captured data parity is the expected reply.
  assign en_expected = dat_q[0] ? oddEnable  : evenEnable;
  assign en_other    = dat_q[0] ? evenEnable : oddEnable;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    pw_d      = pw_q;
    dat_d     = dat_q;
    granted_d = granted_q;
    perr_d    = perr_q;
    tmo_d     = tmo_q;
    att_d     = att_q;
    case (state_q)
      S_IDLE: begin
        if (start && !lock_block) begin
          pw_d      = pw_in;
          dat_d     = data_in;
          retry_d   = '0;
          granted_d = 1'b0;
          perr_d    = 1'b0;
          tmo_d     = 1'b0;
          att_d     = 2'd0;
          cnt_d     = CW'(ARM_CYC - 1);
          state_d   = S_ARM;
        end
      end
      S_ARM: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(HOLD_CYC - 1);
          state_d = S_PRESENT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PRESENT: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(TIMEOUT - 1);
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        // Any activity on the wrong line, including both high, is a parity error.
        if (en_other) begin
          perr_d  = 1'b1;
          state_d = S_DONE;
        end else if (en_expected) begin
          granted_d = 1'b1;
          state_d   = S_DONE;
        end else if (cnt_q == '0) begin
          if (retry_q < CW'(MAX_RETRY)) begin
            state_d = S_GAP;
          end else begin
            tmo_d   = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (state_d == S_DONE)
          att_d = (retry_q > CW'(3)) ? 2'd3 : retry_q[1:0];
      end
      S_GAP: begin
        retry_d = retry_q + 1'b1;
        cnt_d   = CW'(ARM_CYC - 1);
        state_d = S_ARM;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    request_d = (state_d == S_ARM) || (state_d == S_PRESENT) || (state_d == S_WAIT);
    confirm_d = (state_d == S_PRESENT) || (state_d == S_WAIT);
    busy_d    = request_d || (state_d == S_GAP);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      pw_q      <= 4'd0;
      dat_q     <= 4'd0;
      granted_q <= 1'b0;
      perr_q    <= 1'b0;
      tmo_q     <= 1'b0;
      att_q     <= 2'd0;
      request_q <= 1'b0;
      confirm_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pw_q      <= pw_d;
      dat_q     <= dat_d;
      granted_q <= granted_d;
      perr_q    <= perr_d;
      tmo_q     <= tmo_d;
      att_q     <= att_d;
      request_q <= request_d;
      confirm_q <= confirm_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef ACCESS_REQ_LOCKOUT_EN
  logic [1:0] fail_cnt_q, fail_cnt_d;
  logic       locked_q, locked_d;

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    locked_d   = locked_q;
    if (state_q == S_WAIT && state_d == S_DONE) begin
      if (granted_d) begin
        fail_cnt_d = 2'd0;
      end else begin
        if (fail_cnt_q != 2'd3) fail_cnt_d = fail_cnt_q + 2'd1;
        if (fail_cnt_q >= 2'd2) locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt_q <= 2'd0;
      locked_q   <= 1'b0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign lock_block = locked_q;
  assign locked     = locked_q;
`else
  assign lock_block = 1'b0;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign granted     = granted_q;
  assign parity_err  = perr_q;
  assign timeout_err = tmo_q;
  assign attempts    = att_q;
  assign request     = request_q;
  assign confirm     = confirm_q;
  assign passedData  = pw_q;
  assign d           = dat_q;

endmodule
